// File: rtl/complex_pkg.sv
// rtl/complex_pkg.sv - shared types and constants for the complex add/sub sequencer
package complex_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_IM = 2'd1,
        WAIT     = 2'd2,
        HOLD     = 2'd3
    } seq_state_t;

    localparam logic TAG_RE = 1'b0;
    localparam logic TAG_IM = 1'b1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic valid;
        logic tag;
    } tag_entry_t;

endpackage

// File: rtl/addsub_tag_pipe.sv
// rtl/addsub_tag_pipe.sv - valid+tag shift register aligned with the adder pipeline
module addsub_tag_pipe
    import complex_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic push_valid,
    input  logic push_tag,
    output logic pop_valid,
    output logic pop_tag
);

    tag_entry_t stage [DEPTH];

    // Shift every cycle; stage DEPTH-1 lines up with the adder result of the same operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_entry_t'{valid: push_valid, tag: push_tag};
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pop_valid = stage[DEPTH-1].valid;
    assign pop_tag   = stage[DEPTH-1].tag;

endmodule

// File: rtl/complex_addsub_sequencer.sv
// rtl/complex_addsub_sequencer.sv - time-multiplexes a complex add/sub onto one float adder
module complex_addsub_sequencer
    import complex_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADD_LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_op,
    input  logic [DATA_W-1:0] a_re,
    input  logic [DATA_W-1:0] a_im,
    input  logic [DATA_W-1:0] b_re,
    input  logic [DATA_W-1:0] b_im,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_op,
    output logic              add_ce,
    input  logic [DATA_W-1:0] add_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] res_re,
    output logic [DATA_W-1:0] res_im
);

    seq_state_t        state;
    seq_state_t        state_nxt;
    logic [DATA_W-1:0] im_a;
    logic [DATA_W-1:0] im_b;
    logic              load_re;
    logic              load_im;
    logic              push_valid;
    logic              push_tag;
    logic              pop_valid;
    logic              pop_tag;
    logic              cap_re;
    logic              cap_im;

    // The adder only runs outside reset, so stale pipeline contents freeze while rst is high.
    assign add_ce    = ~rst;
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == HOLD);

    // A tag leaving the pipe means add_result belongs to that part in this cycle.
    assign cap_re = pop_valid && (pop_tag == TAG_RE);
    assign cap_im = pop_valid && (pop_tag == TAG_IM);

    addsub_tag_pipe #(
        .DEPTH (ADD_LATENCY)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_tag   (push_tag),
        .pop_valid  (pop_valid),
        .pop_tag    (pop_tag)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle issue controls.
    always_comb begin
        state_nxt  = state;
        load_re    = 1'b0;
        load_im    = 1'b0;
        push_valid = 1'b0;
        push_tag   = TAG_RE;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load_re    = 1'b1;
                    push_valid = 1'b1;
                    push_tag   = TAG_RE;
                    state_nxt  = ISSUE_IM;
                end
            end
            ISSUE_IM: begin
                load_im    = 1'b1;
                push_valid = 1'b1;
                push_tag   = TAG_IM;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (cap_im) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand staging towards the adder and result capture from it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a  <= '0;
            add_b  <= '0;
            add_op <= OP_ADD;
            im_a   <= '0;
            im_b   <= '0;
            res_re <= '0;
            res_im <= '0;
        end else begin
            if (load_re) begin
                add_a  <= a_re;
                add_b  <= b_re;
                add_op <= in_op;
                im_a   <= a_im;
                im_b   <= b_im;
            end
            if (load_im) begin
                add_a <= im_a;
                add_b <= im_b;
            end
            if (cap_re) begin
                res_re <= add_result;
            end
            if (cap_im) begin
                res_im <= add_result;
            end
        end
    end

endmodule

// File: tb/tb_complex_addsub_sequencer.sv
// tb/tb_complex_addsub_sequencer.sv - scoreboard bench for complex_addsub_sequencer
module tb_complex_addsub_sequencer;
    import complex_pkg::*;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid   [3];
    logic        in_ready   [3];
    logic        in_op      [3];
    logic [W-1:0] a_re      [3];
    logic [W-1:0] a_im      [3];
    logic [W-1:0] b_re      [3];
    logic [W-1:0] b_im      [3];
    logic [W-1:0] add_a     [3];
    logic [W-1:0] add_b     [3];
    logic        add_op     [3];
    logic        add_ce     [3];
    logic [W-1:0] add_result[3];
    logic        out_valid  [3];
    logic        out_ready  [3];
    logic [W-1:0] res_re    [3];
    logic [W-1:0] res_im    [3];
    logic        b2b        [3];

    logic [63:0] exp_q [3][$];
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic real f2r(logic [31:0] f);
        real m;
        int  e;
        if (f[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(real r);
        real         a;
        int          e;
        logic        s;
        logic [22:0] m;
        if (r == 0.0) return 32'h0;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 127;
        while (a >= 2.0 && e < 300) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > -300) begin a = a * 2.0; e--; end
        m = 23'($rtoi((a - 1.0) * 8388608.0));
        return {s, 8'(e), m};
    endfunction

    function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b, logic op);
        return r2f(op ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rnd_f();
        return r2f(real'($urandom_range(0, 400)) / 4.0 - 50.0);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int LAT = (g == 0) ? 3 : (g == 1) ? 1 : 15;
        logic [W-1:0] sum;
        int           last_rise;
        int           acc_cyc;
        logic         prev_ov;
        logic [63:0]  ev;

        complex_addsub_sequencer #(
            .DATA_W      (W),
            .ADD_LATENCY (LAT)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_op      (in_op[g]),
            .a_re       (a_re[g]),
            .a_im       (a_im[g]),
            .b_re       (b_re[g]),
            .b_im       (b_im[g]),
            .add_a      (add_a[g]),
            .add_b      (add_b[g]),
            .add_op     (add_op[g]),
            .add_ce     (add_ce[g]),
            .add_result (add_result[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .res_re     (res_re[g]),
            .res_im     (res_im[g])
        );

        // Behavioural adder: result valid LAT edges after the operands are registered.
        assign sum = fadd(add_a[g], add_b[g], add_op[g]);
        if (LAT == 1) begin : comb_add
            assign add_result[g] = sum;
        end else begin : pipe_add
            logic [W-1:0] pq [LAT-1];
            always @(posedge clk) begin
                if (add_ce[g]) begin
                    pq[0] <= sum;
                    for (int i = 1; i < LAT - 1; i++) pq[i] <= pq[i-1];
                end
            end
            assign add_result[g] = pq[LAT-2];
        end

        // Output monitor: latency, throughput and scoreboard comparison.
        always @(negedge clk) begin
            if (rst) begin
                last_rise = -1;
                acc_cyc   = -1;
                prev_ov   = 1'b0;
            end else begin
                if (in_valid[g] && in_ready[g]) acc_cyc = cyc + 1;
                if (out_valid[g] && !prev_ov) begin
                    chk($sformatf("latency_l%0d", LAT), 64'(cyc - acc_cyc), 64'(LAT + 1));
                    if (b2b[g] && last_rise >= 0)
                        chk($sformatf("throughput_l%0d", LAT), 64'(cyc - last_rise), 64'(LAT + 3));
                    last_rise = b2b[g] ? cyc : -1;
                end
                prev_ov = out_valid[g];
                if (out_valid[g] && out_ready[g]) begin
                    if (exp_q[g].size() == 0) begin
                        chk($sformatf("unexpected_out_l%0d", LAT), 64'd1, 64'd0);
                    end else begin
                        ev = exp_q[g].pop_front();
                        chk($sformatf("res_re_l%0d", LAT), 64'(res_re[g]), 64'(ev[63:32]));
                        chk($sformatf("res_im_l%0d", LAT), 64'(res_im[g]), 64'(ev[31:0]));
                    end
                end
            end
        end
    end

    task automatic send(input int g, input logic op, input logic [31:0] ar, input logic [31:0] ai,
                        input logic [31:0] br, input logic [31:0] bi,
                        input logic [31:0] er, input logic [31:0] ei);
        int n = 0;
        in_valid[g] = 1'b1;
        in_op[g]    = op;
        a_re[g]     = ar;
        a_im[g]     = ai;
        b_re[g]     = br;
        b_im[g]     = bi;
        @(negedge clk);
        while (!in_ready[g] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[g]) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid[g] = 1'b0;
            return;
        end
        exp_q[g].push_back({er, ei});
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
        a_re[g]     = $urandom;
        a_im[g]     = $urandom;
        b_re[g]     = $urandom;
        b_im[g]     = $urandom;
        in_op[g]    = 1'($urandom_range(0, 1));
    endtask

    task automatic send_rand(input int g);
        logic [31:0] ar, ai, br, bi;
        logic        op;
        ar = rnd_f();
        ai = rnd_f();
        br = rnd_f();
        bi = rnd_f();
        op = $urandom_range(0, 1) == 1 ? OP_SUB : OP_ADD;
        send(g, op, ar, ai, br, bi, fadd(ar, br, op), fadd(ai, bi, op));
    endtask

    task automatic drain(input int g);
        int n = 0;
        while (exp_q[g].size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q[g].size() != 0) chk("drain_timeout", 64'(exp_q[g].size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ov(input int g);
        int n = 0;
        while (!out_valid[g] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid[g]) chk("out_valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not reach the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] dropped;
        int          n;
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            in_valid[g]  = 1'b0;
            in_op[g]     = OP_ADD;
            a_re[g]      = '0;
            a_im[g]      = '0;
            b_re[g]      = '0;
            b_im[g]      = '0;
            out_ready[g] = 1'b1;
            b2b[g]       = 1'b0;
        end

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready[0]), 64'd0);
        chk("rst_add_ce", 64'(add_ce[0]), 64'd0);
        chk("rst_out_valid", 64'(out_valid[0]), 64'd0);
        chk("rst_add_a", 64'(add_a[0]), 64'd0);
        chk("rst_add_b", 64'(add_b[0]), 64'd0);
        chk("rst_add_op", 64'(add_op[0]), 64'd0);
        chk("rst_res_re", 64'(res_re[0]), 64'd0);
        chk("rst_res_im", 64'(res_im[0]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready[0]), 64'd1);
        chk("idle_add_ce", 64'(add_ce[0]), 64'd1);
        @(posedge clk);
        #1;

        // Directed add and subtract.
        send(0, OP_ADD, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40400000, 32'h40000000);
        drain(0);
        send(0, OP_SUB, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000000);
        drain(0);

        // Back-pressure: results held, a second offer is refused.
        out_ready[0] = 1'b0;
        send(0, OP_ADD, 32'h40400000, 32'h40800000, 32'h3F800000, 32'h3F800000, 32'h40800000, 32'h40A00000);
        wait_ov(0);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b1;
        a_re[0]     = 32'h41200000;
        a_im[0]     = 32'h41200000;
        repeat (10) begin
            @(negedge clk);
            chk("hold_res_re", 64'(res_re[0]), 64'h40800000);
            chk("hold_res_im", 64'(res_im[0]), 64'h40A00000);
            chk("hold_in_ready", 64'(in_ready[0]), 64'd0);
            chk("hold_out_valid", 64'(out_valid[0]), 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("release_in_ready_lo", 64'(in_ready[0]), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("release_in_ready_hi", 64'(in_ready[0]), 64'd1);
        chk("release_out_valid", 64'(out_valid[0]), 64'd0);
        @(posedge clk);
        #1;

        // Reset two edges after accept discards the transaction.
        send(0, OP_ADD, 32'h40A00000, 32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h40C00000, 32'h40E00000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 64'(in_ready[0]), 64'd0);
        chk("midrst_add_ce", 64'(add_ce[0]), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dropped = exp_q[0].pop_back();
        repeat (7) begin
            @(negedge clk);
            chk("midrst_no_out_valid", 64'(out_valid[0]), 64'd0);
        end
        chk("midrst_in_ready_after", 64'(in_ready[0]), 64'd1);
        @(posedge clk);
        #1;
        send(0, OP_ADD, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40400000, 32'h40000000);
        drain(0);

        // Operand noise and in_valid toggling while busy.
        for (int t = 0; t < 3; t++) begin
            send_rand(0);
            n = 0;
            while (!in_ready[0] && n < 100) begin
                in_valid[0] = 1'($urandom_range(0, 1));
                in_op[0]    = 1'($urandom_range(0, 1));
                a_re[0]     = $urandom;
                a_im[0]     = $urandom;
                b_re[0]     = $urandom;
                b_im[0]     = $urandom;
                @(posedge clk);
                #1;
                n++;
            end
            in_valid[0] = 1'b0;
        end
        drain(0);

        // Back-to-back at the latency extremes.
        b2b[1] = 1'b1;
        b2b[2] = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) send_rand(1);
                drain(1);
            end
            begin
                for (int i = 0; i < 5; i++) send_rand(2);
                drain(2);
            end
        join
        b2b[1] = 1'b0;
        b2b[2] = 1'b0;

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
